// File: rtl/membus_router.sv
// membus_router: single-master to NSLV-slave address router. A request is
// decoded against per-slave base/mask pairs, forwarded to the winning slave,
// and completed with that slave's read data. A decode miss or a slave that
// does not answer within TIMEOUT cycles completes with ERR_DATA and m_err=1.
module membus_router #(
  parameter int unsigned          NSLV     = 4,
  parameter logic [NSLV*32-1:0]   SLV_BASE = {32'h03000000, 32'h02000000, 32'h00000000, 32'h00000000},
  parameter logic [NSLV*32-1:0]   SLV_MASK = {32'hFF000000, 32'hFFFFFFFF, 32'hFE000000, 32'hFFFFFC00},
  parameter int unsigned          TIMEOUT  = 255,
  parameter logic [31:0]          ERR_DATA = 32'hDEADBEEF
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 m_valid,
  output logic                 m_ready,
  input  logic [31:0]          m_addr,
  input  logic [31:0]          m_wdata,
  input  logic [3:0]           m_wstrb,
  output logic [31:0]          m_rdata,
  output logic                 m_err,
  output logic [NSLV-1:0]      s_valid,
  input  logic [NSLV-1:0]      s_ready,
  output logic [31:0]          s_addr,
  output logic [31:0]          s_wdata,
  output logic [3:0]           s_wstrb,
  input  logic [NSLV*32-1:0]   s_rdata,
  output logic [15:0]          err_count
);

  localparam int unsigned SW = (NSLV > 1) ? $clog2(NSLV) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t        state;
  logic [SW-1:0] sel;
  logic [15:0]   cnt;

  logic          hit;
  logic [SW-1:0] hit_idx;
  logic          sel_ready;
  logic [31:0]   sel_rdata;

  // Address decode: lowest-indexed matching slave wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < NSLV; i++) begin
      if (!hit && ((m_addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32])) begin
        hit     = 1'b1;
        hit_idx = SW'(i);
      end
    end
  end

  // Only the selected slave's handshake and data are observed.
  always_comb begin
    sel_ready = s_ready[sel];
    sel_rdata = s_rdata[32*int'(sel) +: 32];
  end

  // Transaction FSM with registered master/slave handshake outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      sel       <= '0;
      cnt       <= '0;
      m_ready   <= 1'b0;
      m_err     <= 1'b0;
      m_rdata   <= '0;
      s_valid   <= '0;
      s_addr    <= '0;
      s_wdata   <= '0;
      s_wstrb   <= '0;
      err_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (m_valid) begin
            s_addr  <= m_addr;
            s_wdata <= m_wdata;
            s_wstrb <= m_wstrb;
            if (hit) begin
              state   <= ACTIVE;
              sel     <= hit_idx;
              s_valid <= NSLV'(1) << hit_idx;
              cnt     <= '0;
            end else begin
              state   <= RESP;
              m_ready <= 1'b1;
              m_err   <= 1'b1;
              m_rdata <= ERR_DATA;
              if (err_count != '1) err_count <= err_count + 16'd1;
            end
          end
        end
        ACTIVE: begin
          // A ready on the timeout edge still counts as a normal completion.
          if (sel_ready) begin
            state   <= RESP;
            s_valid <= '0;
            m_ready <= 1'b1;
            m_err   <= 1'b0;
            m_rdata <= sel_rdata;
          end else if (cnt == 16'(TIMEOUT - 1)) begin
            state   <= RESP;
            s_valid <= '0;
            m_ready <= 1'b1;
            m_err   <= 1'b1;
            m_rdata <= ERR_DATA;
            if (err_count != '1) err_count <= err_count + 16'd1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RESP: begin
          state   <= IDLE;
          m_ready <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          m_ready <= 1'b0;
          s_valid <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_membus_router.sv
// tb_membus_router: directed transactions against membus_router with a
// transaction-level predictor that expands each request into the expected
// per-cycle output timeline, checked every cycle by one compare process.
module tb_membus_router;

  localparam int unsigned NS   = 4;
  localparam int unsigned TO   = 8;
  localparam logic [31:0] ERRD = 32'hDEADBEEF;

  logic              clk = 1'b0;
  logic              resetn;
  logic              m_valid;
  logic              m_ready;
  logic [31:0]       m_addr;
  logic [31:0]       m_wdata;
  logic [3:0]        m_wstrb;
  logic [31:0]       m_rdata;
  logic              m_err;
  logic [NS-1:0]     s_valid;
  logic [NS-1:0]     s_ready;
  logic [31:0]       s_addr;
  logic [31:0]       s_wdata;
  logic [3:0]        s_wstrb;
  logic [NS*32-1:0]  s_rdata;
  logic [15:0]       err_count;

  int total;
  int bad;

  // Slave behaviour: wait cycles before ready (-1 = never), data, idle ready noise.
  logic [31:0]   rdata_cfg [NS];
  int            wait_cfg  [NS];
  logic [NS-1:0] ready_idle;
  int            seen      [NS];

  // Address map as written in the requirements (slave0..slave3).
  logic [31:0] base_tab [NS] = '{32'h00000000, 32'h00000000, 32'h02000000, 32'h03000000};
  logic [31:0] mask_tab [NS] = '{32'hFFFFFC00, 32'hFE000000, 32'hFFFFFFFF, 32'hFF000000};

  typedef struct {
    logic [NS-1:0] sv;
    logic          mr;
    logic          me;
    logic [31:0]   rd;
    logic [15:0]   ec;
    logic [31:0]   sa;
    logic [31:0]   sd;
    logic [3:0]    ss;
  } rec_t;

  rec_t        q[$];
  rec_t        cmp_e;
  logic [31:0] exp_rdata;
  logic [15:0] exp_errc;
  logic [31:0] exp_sa;
  logic [31:0] exp_sd;
  logic [3:0]  exp_ss;
  logic        checking;

  membus_router #(
    .NSLV    (NS),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_wstrb   (m_wstrb),
    .m_rdata   (m_rdata),
    .m_err     (m_err),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_addr    (s_addr),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .s_rdata   (s_rdata),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  for (genvar g = 0; g < NS; g++) begin : g_rd
    assign s_rdata[g*32 +: 32] = rdata_cfg[g];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < NS; i++)
      if ((a & mask_tab[i]) == base_tab[i]) return i;
    return -1;
  endfunction

  // Expand one request into the cycle-by-cycle outputs that must follow its sampling edge.
  function automatic void predict(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
    rec_t r;
    int   sel;
    int   n;
    logic e;
    logic [31:0] data;
    sel    = decode(a);
    exp_sa = a;
    exp_sd = d;
    exp_ss = st;
    r.sa = a; r.sd = d; r.ss = st; r.me = 1'b0;
    if (sel < 0) begin
      n    = 0;
      e    = 1'b1;
      data = ERRD;
    end else if (wait_cfg[sel] >= 0 && wait_cfg[sel] < int'(TO)) begin
      n    = wait_cfg[sel] + 1;
      e    = 1'b0;
      data = rdata_cfg[sel];
    end else begin
      n    = TO;
      e    = 1'b1;
      data = ERRD;
    end
    for (int k = 0; k < n; k++) begin
      r.sv = '0;
      r.sv[sel] = 1'b1;
      r.mr = 1'b0;
      r.rd = exp_rdata;
      r.ec = exp_errc;
      q.push_back(r);
    end
    exp_rdata = data;
    if (e && exp_errc != 16'hFFFF) exp_errc = exp_errc + 16'd1;
    r.sv = '0;
    r.mr = 1'b1;
    r.me = e;
    r.rd = exp_rdata;
    r.ec = exp_errc;
    q.push_back(r);
  endfunction

  // Slave responders, driven away from the sampling edge.
  initial begin
    s_ready = '0;
    for (int i = 0; i < NS; i++) seen[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NS; i++) begin
        if (s_valid[i]) begin
          s_ready[i] = (wait_cfg[i] >= 0) && (seen[i] == wait_cfg[i]);
          seen[i]++;
        end else begin
          s_ready[i] = ready_idle[i];
          seen[i]    = 0;
        end
      end
    end
  end

  // Per-cycle comparison against the predicted timeline (idle expectations when empty).
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (resetn && checking) begin
        if (q.size() > 0) begin
          cmp_e = q.pop_front();
        end else begin
          cmp_e.sv = '0;
          cmp_e.mr = 1'b0;
          cmp_e.me = 1'b0;
          cmp_e.rd = exp_rdata;
          cmp_e.ec = exp_errc;
          cmp_e.sa = exp_sa;
          cmp_e.sd = exp_sd;
          cmp_e.ss = exp_ss;
        end
        chk("s_valid", 32'(s_valid), 32'(cmp_e.sv));
        chk("m_ready", 32'(m_ready), 32'(cmp_e.mr));
        chk("m_rdata", m_rdata, cmp_e.rd);
        chk("err_count", 32'(err_count), 32'(cmp_e.ec));
        chk("s_addr", s_addr, cmp_e.sa);
        chk("s_wdata", s_wdata, cmp_e.sd);
        chk("s_wstrb", 32'(s_wstrb), 32'(cmp_e.ss));
        if (cmp_e.mr) chk("m_err", 32'(m_err), 32'(cmp_e.me));
      end
    end
  end

  // Issue one request from an IDLE-cycle negedge and pin its hand-computed outcome.
  task automatic txn(input string nm, input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                     input int e_lat, input int e_svc, input logic [31:0] e_data, input logic e_err);
    int          k;
    int          svc;
    bit          done;
    logic        got_err;
    logic [31:0] got_data;
    predict(a, d, st);
    m_valid = 1'b1;
    m_addr  = a;
    m_wdata = d;
    m_wstrb = st;
    k = 0; svc = 0; done = 0; got_err = 1'bx; got_data = 'x;
    while (!done && k < 64) begin
      @(posedge clk);
      #2;
      k++;
      if (k == 1) begin
        m_valid = 1'b0;
        m_addr  = $urandom;
        m_wdata = $urandom;
        m_wstrb = 4'($urandom);
      end
      if (s_valid != '0) svc++;
      if (m_ready) begin
        done     = 1;
        got_err  = m_err;
        got_data = m_rdata;
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s_no_m_ready actual=none required=m_ready within 64 cycles", nm);
    end
    chk({nm, "_latency"}, 32'(k), 32'(e_lat));
    chk({nm, "_svalid_cycles"}, 32'(svc), 32'(e_svc));
    chk({nm, "_rdata"}, got_data, e_data);
    chk({nm, "_err"}, 32'(got_err), 32'(e_err));
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0;
    resetn = 1'b0; checking = 1'b0;
    m_valid = 1'b0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
    rdata_cfg = '{32'h12345678, 32'h11112222, 32'h33334444, 32'h55556666};
    wait_cfg  = '{0, -1, 2, 3};
    ready_idle = '0;
    exp_rdata = '0; exp_errc = '0; exp_sa = '0; exp_sd = '0; exp_ss = '0;

    #13;
    chk("rst_m_ready", 32'(m_ready), 32'd0);
    chk("rst_m_err", 32'(m_err), 32'd0);
    chk("rst_s_valid", 32'(s_valid), 32'd0);
    chk("rst_m_rdata", m_rdata, 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_s_addr", s_addr, 32'd0);

    @(negedge clk);
    resetn = 1'b1;
    checking = 1'b1;

    txn("rd_s0_zero_wait", 32'h00000100, 32'h0, 4'h0, 2, 1, 32'h12345678, 1'b0);
    ready_idle = '1;
    txn("wr_s3_wait3", 32'h03000010, 32'hA5A5A5A5, 4'b0011, 5, 4, 32'h55556666, 1'b0);
    txn("rd_miss", 32'h02000004, 32'h0, 4'h0, 1, 0, 32'hDEADBEEF, 1'b1);
    chk("miss_err_count", 32'(err_count), 32'd1);
    wait_cfg[1] = -1;
    txn("rd_s1_timeout", 32'h00100000, 32'h0, 4'h0, 9, 8, 32'hDEADBEEF, 1'b1);
    chk("timeout_err_count", 32'(err_count), 32'd2);
    wait_cfg[1] = 7;
    txn("rd_s1_ready_last", 32'h00100000, 32'h0, 4'hF, 9, 8, 32'h11112222, 1'b0);
    wait_cfg[0] = 1;
    txn("rd_prio_s0", 32'h00000200, 32'h0, 4'h0, 3, 2, 32'h12345678, 1'b0);
    txn("wr_s2_exact", 32'h02000000, 32'h0BADF00D, 4'b1100, 4, 3, 32'h33334444, 1'b0);
    txn("rd_s3_top", 32'h03FFFFFC, 32'h0, 4'h0, 5, 4, 32'h55556666, 1'b0);
    chk("errs_held", 32'(err_count), 32'd2);

    checking = 1'b0;
    wait_cfg[1] = -1;
    m_valid = 1'b1;
    m_addr  = 32'h00100000;
    @(posedge clk);
    #2;
    m_valid = 1'b0;
    chk("mid_s_valid_active", 32'(s_valid), 32'h2);
    @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    chk("mid_rst_s_valid", 32'(s_valid), 32'd0);
    chk("mid_rst_m_ready", 32'(m_ready), 32'd0);
    chk("mid_rst_err_count", 32'(err_count), 32'd0);
    chk("mid_rst_m_rdata", m_rdata, 32'd0);
    q.delete();
    exp_rdata = '0; exp_errc = '0; exp_sa = '0; exp_sd = '0; exp_ss = '0;
    @(negedge clk);
    resetn = 1'b1;
    checking = 1'b1;
    wait_cfg[0] = 0;
    txn("rd_after_rst", 32'h00000100, 32'h0, 4'h0, 2, 1, 32'h12345678, 1'b0);
    chk("after_rst_err_count", 32'(err_count), 32'd0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/membus_router.md
MEMBUS_ROUTER -- requirements
Module: membus_router

Interface
REQ-001 SHALL have parameter NSLV, default 4: number of slave ports (1..16).
REQ-002 SHALL have parameter SLV_BASE, default {32'h03000000, 32'h02000000, 32'h00000000, 32'h00000000} (slave3..slave0): per-slave match base, NSLV*32 bits packed.
REQ-003 SHALL have parameter SLV_MASK, default {32'hFF000000, 32'hFFFFFFFF, 32'hFE000000, 32'hFFFFFC00}: per-slave match mask, NSLV*32 bits packed.
REQ-004 SHALL have parameter TIMEOUT, default 255: cycles in ACTIVE before forced error completion (1..65535).
REQ-005 SHALL have parameter ERR_DATA, default 32'hDEADBEEF: rdata returned on any error completion.
REQ-006 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-007 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have master ports m_valid in 1, m_ready out 1, m_addr in 32, m_wdata in 32, m_wstrb in 4, m_rdata out 32, m_err out 1 (error flag, valid while m_ready=1).
REQ-009 SHALL have slave ports s_valid out NSLV (one-hot), s_ready in NSLV, s_addr out 32, s_wdata out 32, s_wstrb out 4 (all three shared, registered), s_rdata in NSLV*32 (slave i at bits [32*i+31:32*i]).
REQ-010 SHALL have port err_count, output, 16 bits: saturating count of error completions.

Function
REQ-011 SHALL implement states IDLE, ACTIVE, RESP.
REQ-012 In IDLE with m_valid=1 at a clock edge, SHALL latch m_addr/m_wdata/m_wstrb into s_addr/s_wdata/s_wstrb and decode: slave i matches when (m_addr & SLV_MASK[i]) == SLV_BASE[i]; lowest matching index wins.
REQ-013 On a match, SHALL enter ACTIVE with s_valid[sel]=1 and all other s_valid bits 0; timeout counter cleared to 0.
REQ-014 On no match, SHALL enter RESP directly with m_rdata=ERR_DATA, m_err=1; no s_valid asserted.
REQ-015 In ACTIVE, when s_ready[sel]=1 at an edge, SHALL capture s_rdata of sel into m_rdata, clear s_valid, set m_err=0, enter RESP; s_ready of unselected slaves SHALL be ignored.
REQ-016 In ACTIVE without s_ready[sel], counter SHALL increment per cycle; when counter reaches TIMEOUT-1 without s_ready, SHALL clear s_valid and enter RESP with m_rdata=ERR_DATA, m_err=1; s_ready on that same edge takes precedence (normal completion).
REQ-017 In RESP, m_ready SHALL be 1 for exactly one cycle, then return to IDLE; m_valid is not sampled in RESP.
REQ-018 Latency: zero-wait slave gives m_ready 2 cycles after the sampling edge; decode miss gives m_ready 1 cycle after it.
REQ-019 m_ready, m_err and s_valid SHALL be registered outputs; m_rdata SHALL hold its value outside RESP.
REQ-020 m_valid deasserting during ACTIVE SHALL NOT abort the transaction; it completes normally.
REQ-021 err_count SHALL increment by 1 on each entry to RESP with m_err=1 and saturate at 16'hFFFF.

Reset
REQ-022 resetn=0 SHALL asynchronously force state IDLE, m_ready=0, m_err=0, m_rdata=0, s_valid=0, s_addr=0, s_wdata=0, s_wstrb=0, counter=0, err_count=0, including mid-transaction.
REQ-023 After resetn rises, the first m_valid SHALL be sampled at the first rising edge with resetn=1.

Verification
REQ-024 Read 0x00000100, slave0 s_ready tied 1, s_rdata0=0x12345678 -> s_valid=4'b0001 one cycle, m_ready 2 cycles after sample, m_rdata=0x12345678, m_err=0.
REQ-025 Write 0x03000010 wdata 0xA5A5A5A5 wstrb 4'b0011 -> s_valid=4'b1000, s_wdata=0xA5A5A5A5, s_wstrb=4'b0011 until s_ready3 (after 3 wait cycles), then m_ready pulse.
REQ-026 Read 0x02000004 (no match) -> no s_valid, m_ready 1 cycle after sample, m_rdata=0xDEADBEEF, m_err=1, err_count=1.
REQ-027 Read 0x00100000, slave1 never ready, TIMEOUT=8 -> s_valid[1] high 8 cycles then drops, m_err=1, m_rdata=0xDEADBEEF; s_ready1 on the 8th cycle instead -> m_err=0.
REQ-028 resetn pulsed low during ACTIVE -> s_valid=0, m_ready=0, err_count=0 immediately (no clock edge); next transaction completes normally.
REQ-029 Address 0x00000200 matching slaves 0 and 1 -> only s_valid[0] asserted (priority).
